pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the milano core. It sits beside the IF, ID and EX stages and decides each cycle whether the PC/IF-ID register holds, whether the ID-EX register takes the decoded instruction or a bubble, and whether EX holds. It owns three things: the data-memory request handshake for the LSU op in EX, load-use hazard detection against the instruction in ID, and the flush/redirect on a taken jump. Decode-side instruction info comes straight from the decoder; the block keeps its own shadow of the EX-stage instruction.

---
 rtl/pipe_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the milano core.
// Owns the data-memory handshake for the LSU op in EX, load-use hazard
// detection against ID, and the flush/redirect on a taken jump.
module pipe_ctrl (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_rs1_used_i,
    input  logic        id_rs2_used_i,
    input  logic [4:0]  id_rd_addr_i,
    input  logic        id_rd_wr_en_i,
    input  logic        id_lsu_req_i,
    input  logic        id_lsu_we_i,
    input  logic        ex_jump_taken_i,
    input  logic [31:0] ex_jump_target_i,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic        data_req_o,
    output logic        pc_stall_o,
    output logic        ex_stall_o,
    output logic        idex_bubble_o,
    output logic        ifid_flush_o,
    output logic        pc_set_o,
    output logic [31:0] pc_target_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    lsu_state_e  state_q, state_d;

    logic        ex_valid_q, ex_valid_d;
    logic        ex_lsu_q, ex_lsu_d;
    logic        ex_load_q, ex_load_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic        lsu_ex;
    logic        lsu_stall;
    logic        lsu_req;
    logic        luh;
    logic        jmp;
    logic        rs1_hit;
    logic        rs2_hit;

    // The rd write enable is not needed here: a load always writes its rd,
    // and x0 is excluded explicitly in the hazard check.
    logic        unused_rd_wr_en;
    assign unused_rd_wr_en = id_rd_wr_en_i;

    assign lsu_ex = ex_valid_q & ex_lsu_q;

    // LSU handshake: keep the request up until granted, then hold EX until the response.
    always_comb begin
        state_d   = state_q;
        lsu_req   = 1'b0;
        lsu_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (lsu_ex) begin
                    lsu_req   = 1'b1;
                    lsu_stall = 1'b1;
                    state_d   = data_gnt_i ? RESP : REQ;
                end
            end
            REQ: begin
                lsu_req   = 1'b1;
                lsu_stall = 1'b1;
                if (data_gnt_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                lsu_stall = ~data_rvalid_i;
                if (data_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Only loads create a hazard; other results reach ID through the EX bypass.
    assign rs1_hit = id_rs1_used_i & (id_rs1_addr_i == ex_rd_q);
    assign rs2_hit = id_rs2_used_i & (id_rs2_addr_i == ex_rd_q);
    assign luh     = id_valid_i & ex_valid_q & ex_load_q & (ex_rd_q != 5'd0)
                   & (rs1_hit | rs2_hit);

    // A jump is only honoured when no memory op is in flight or pending in EX.
    assign jmp = ex_jump_taken_i & (state_q == IDLE) & ~lsu_ex;

    // Pipeline control outputs: jump beats stall beats load-use.
    always_comb begin
        pc_stall_o    = 1'b0;
        idex_bubble_o = 1'b0;
        ifid_flush_o  = 1'b0;
        pc_set_o      = 1'b0;
        pc_target_o   = 32'd0;
        if (jmp) begin
            pc_set_o      = 1'b1;
            pc_target_o   = ex_jump_target_i;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (lsu_stall) begin
            pc_stall_o    = 1'b1;
        end else if (luh) begin
            pc_stall_o    = 1'b1;
            idex_bubble_o = 1'b1;
        end
    end

    assign data_req_o = lsu_req;
    assign ex_stall_o = lsu_stall;

    // EX shadow follows ID-EX: hold on stall, take a bubble or the decoded instruction otherwise.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_lsu_d   = ex_lsu_q;
        ex_load_d  = ex_load_q;
        ex_rd_d    = ex_rd_q;
        if (!lsu_stall) begin
            if (idex_bubble_o) begin
                ex_valid_d = 1'b0;
            end else begin
                ex_valid_d = id_valid_i;
                ex_lsu_d   = id_lsu_req_i;
                ex_load_d  = id_lsu_req_i & ~id_lsu_we_i;
                ex_rd_d    = id_rd_addr_i;
            end
        end
    end

    // Stall counter saturates at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

    // State, shadow and counter registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ex_valid_q  <= 1'b0;
            ex_lsu_q    <= 1'b0;
            ex_load_q   <= 1'b0;
            ex_rd_q     <= 5'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            ex_valid_q  <= ex_valid_d;
            ex_lsu_q    <= ex_lsu_d;
            ex_load_q   <= ex_load_d;
            ex_rd_q     <= ex_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl.
module tb_pipe_ctrl;

    logic        clk_i;
    logic        rst_ni;
    logic        id_valid_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_rs1_used_i;
    logic        id_rs2_used_i;
    logic [4:0]  id_rd_addr_i;
    logic        id_rd_wr_en_i;
    logic        id_lsu_req_i;
    logic        id_lsu_we_i;
    logic        ex_jump_taken_i;
    logic [31:0] ex_jump_target_i;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic        data_req_o;
    logic        pc_stall_o;
    logic        ex_stall_o;
    logic        idex_bubble_o;
    logic        ifid_flush_o;
    logic        pc_set_o;
    logic [31:0] pc_target_o;
    logic [31:0] stall_cnt_o;

    typedef struct {
        string       tag;
        logic [69:0] vec;
    } exp_t;

    exp_t        sb[$];
    int          vectors;
    int          miscompares;
    logic [31:0] expCnt;

    pipe_ctrl dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .id_valid_i       (id_valid_i),
        .id_rs1_addr_i    (id_rs1_addr_i),
        .id_rs2_addr_i    (id_rs2_addr_i),
        .id_rs1_used_i    (id_rs1_used_i),
        .id_rs2_used_i    (id_rs2_used_i),
        .id_rd_addr_i     (id_rd_addr_i),
        .id_rd_wr_en_i    (id_rd_wr_en_i),
        .id_lsu_req_i     (id_lsu_req_i),
        .id_lsu_we_i      (id_lsu_we_i),
        .ex_jump_taken_i  (ex_jump_taken_i),
        .ex_jump_target_i (ex_jump_target_i),
        .data_gnt_i       (data_gnt_i),
        .data_rvalid_i    (data_rvalid_i),
        .data_req_o       (data_req_o),
        .pc_stall_o       (pc_stall_o),
        .ex_stall_o       (ex_stall_o),
        .idex_bubble_o    (idex_bubble_o),
        .ifid_flush_o     (ifid_flush_o),
        .pc_set_o         (pc_set_o),
        .pc_target_o      (pc_target_o),
        .stall_cnt_o      (stall_cnt_o)
    );

    // Free-running core clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic setId(input logic v, input logic [4:0] rs1, input logic rs1u,
                         input logic [4:0] rs2, input logic rs2u, input logic [4:0] rd,
                         input logic rdw, input logic lsu, input logic we);
        id_valid_i    = v;
        id_rs1_addr_i = rs1;
        id_rs1_used_i = rs1u;
        id_rs2_addr_i = rs2;
        id_rs2_used_i = rs2u;
        id_rd_addr_i  = rd;
        id_rd_wr_en_i = rdw;
        id_lsu_req_i  = lsu;
        id_lsu_we_i   = we;
    endtask

    // Push the outputs expected for the inputs just driven.
    task automatic applyStimulus(input string tag, input logic req, input logic pcs,
                                 input logic exs, input logic bub, input logic flush,
                                 input logic set, input logic [31:0] tgt);
        exp_t e;
        e.tag = tag;
        e.vec = {req, pcs, exs, bub, flush, set, tgt, expCnt};
        sb.push_back(e);
    endtask

    // Let the combinational outputs settle, then compare against the oldest expectation.
    task automatic checkOutput();
        exp_t        e;
        logic [69:0] obs;
        #1;
        obs = {data_req_o, pc_stall_o, ex_stall_o, idex_bubble_o, ifid_flush_o,
               pc_set_o, pc_target_o, stall_cnt_o};
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.vec) else begin
                miscompares++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.vec);
            end
            if (e.vec[68] && (expCnt != 32'hFFFF_FFFF)) begin
                expCnt = expCnt + 32'd1;
            end
        end
    endtask

    // Directed sequence: reset, store, load-use, jump, spurious jump, saturation.
    initial begin
        vectors          = 0;
        miscompares      = 0;
        expCnt           = 32'd0;
        rst_ni           = 1'b0;
        ex_jump_taken_i  = 1'b0;
        ex_jump_target_i = 32'd0;
        data_gnt_i       = 1'b0;
        data_rvalid_i    = 1'b0;
        setId(0, 0, 0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk_i);
        applyStimulus("por", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); rst_ni = 1'b1;

        // Reset in the middle of an ungranted store.
        setId(1, 1, 1, 2, 1, 0, 0, 1, 1);
        applyStimulus("rst_st_id", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); setId(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("rst_st_issue", 1, 1, 1, 0, 0, 0, 32'd0); checkOutput();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            applyStimulus("rst_st_req", 1, 1, 1, 0, 0, 0, 32'd0); checkOutput();
        end
        @(negedge clk_i);
        applyStimulus("rst_pre_cnt5", 1, 1, 1, 0, 0, 0, 32'd0); checkOutput();
        #2; rst_ni = 1'b0; expCnt = 32'd0;
        applyStimulus("rst_async", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); data_gnt_i = 1'b1; data_rvalid_i = 1'b1;
        applyStimulus("rst_hold", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); rst_ni = 1'b1;
        applyStimulus("rst_late_rsp", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();

        // Store with grant on the fourth request cycle, response two cycles later.
        @(negedge clk_i); data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        setId(1, 1, 1, 2, 1, 0, 0, 1, 1);
        applyStimulus("st_id", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); setId(1, 8, 1, 9, 1, 7, 1, 0, 0);
        applyStimulus("st_issue", 1, 1, 1, 0, 0, 0, 32'd0); checkOutput();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            applyStimulus("st_req", 1, 1, 1, 0, 0, 0, 32'd0); checkOutput();
        end
        @(negedge clk_i); data_gnt_i = 1'b1;
        applyStimulus("st_gnt", 1, 1, 1, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); data_gnt_i = 1'b0;
        applyStimulus("st_resp", 0, 1, 1, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); data_rvalid_i = 1'b1;
        applyStimulus("st_rvalid", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); data_rvalid_i = 1'b0; setId(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("st_done_cnt5", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();

        // lw x5 then add x6,x5,x1 with immediate grant and response.
        @(negedge clk_i); setId(1, 2, 1, 0, 0, 5, 1, 1, 0);
        applyStimulus("lu_id", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); setId(1, 5, 1, 1, 1, 6, 1, 0, 0); data_gnt_i = 1'b1;
        applyStimulus("lu_issue", 1, 1, 1, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); data_gnt_i = 1'b0; data_rvalid_i = 1'b1;
        applyStimulus("lu_rvalid_bubble", 0, 1, 0, 1, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); data_rvalid_i = 1'b0;
        applyStimulus("lu_advance", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); setId(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("lu_add_in_ex", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();

        // Same sequence targeting x0: no hazard.
        @(negedge clk_i); setId(1, 2, 1, 0, 0, 0, 1, 1, 0);
        applyStimulus("lz_id", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); setId(1, 0, 1, 1, 1, 6, 1, 0, 0); data_gnt_i = 1'b1;
        applyStimulus("lz_issue", 1, 1, 1, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); data_gnt_i = 1'b0; data_rvalid_i = 1'b1;
        applyStimulus("lz_rvalid_nobubble", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); data_rvalid_i = 1'b0; setId(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("lz_done", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();

        // Taken jump while ID reads the EX destination.
        @(negedge clk_i); setId(1, 1, 1, 2, 1, 5, 1, 0, 0);
        applyStimulus("j_prod", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); setId(1, 5, 1, 0, 0, 6, 1, 0, 0);
        ex_jump_taken_i = 1'b1; ex_jump_target_i = 32'h0000_0100;
        applyStimulus("j_take", 0, 0, 0, 1, 1, 1, 32'h0000_0100); checkOutput();
        @(negedge clk_i); ex_jump_taken_i = 1'b0;
        applyStimulus("j_after_tgt0", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();

        // Jump during a load response is ignored; honoured once back in IDLE.
        @(negedge clk_i); setId(1, 2, 1, 0, 0, 3, 1, 1, 0); ex_jump_target_i = 32'h0000_0200;
        applyStimulus("s_id", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); setId(0, 0, 0, 0, 0, 0, 0, 0, 0); data_gnt_i = 1'b1;
        applyStimulus("s_issue", 1, 1, 1, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); data_gnt_i = 1'b0; ex_jump_taken_i = 1'b1;
        applyStimulus("s_resp_jump_ign", 0, 1, 1, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); data_rvalid_i = 1'b1;
        applyStimulus("s_rvalid_jump_ign", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); data_rvalid_i = 1'b0;
        applyStimulus("s_idle_jump", 0, 0, 0, 1, 1, 1, 32'h0000_0200); checkOutput();
        @(negedge clk_i); ex_jump_taken_i = 1'b0;
        applyStimulus("s_clear", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();

        // Counter saturation with a store that is never granted.
        @(negedge clk_i); setId(1, 1, 1, 2, 1, 0, 0, 1, 1);
        applyStimulus("t_id", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();
        @(negedge clk_i); setId(0, 0, 0, 0, 0, 0, 0, 0, 0);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        expCnt = 32'hFFFF_FFFE;
        applyStimulus("t_preload", 1, 1, 1, 0, 0, 0, 32'd0); checkOutput();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            applyStimulus("t_saturate", 1, 1, 1, 0, 0, 0, 32'd0); checkOutput();
        end

        @(negedge clk_i); rst_ni = 1'b0; expCnt = 32'd0;
        applyStimulus("final_reset", 0, 0, 0, 0, 0, 0, 32'd0); checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
